// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per clock.
// Optional flush input (abort in RUN/FINISH) is compiled in with `define MULDIV_FLUSH_EN.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MULDIV_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               nrem_q, nrem_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   raw_q, raw_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial, diff;
    logic               qbit;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    // Signed magnitudes: the most negative value negates to itself, read as unsigned 2^(WIDTH-1).
    assign a_neg = op[0] & op1[WIDTH-1];
    assign b_neg = op[0] & op2[WIDTH-1];
    assign a_mag = a_neg ? -op1 : op1;
    assign b_mag = b_neg ? -op2 : op2;

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign trial    = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = trial - {1'b0, b_q};
    assign qbit     = ~diff[WIDTH];
    assign div_next = {(qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};

    assign prod   = neg_q  ? -acc_q : acc_q;
    assign quo    = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem    = nrem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // Divide by zero bypasses sign correction: raw dividend in hi, all ones in lo.
    assign res_hi = !is_div_q ? prod[2*WIDTH-1:WIDTH] : (zero_q ? raw_q : rem);
    assign res_lo = !is_div_q ? prod[WIDTH-1:0]       : (zero_q ? '1    : quo);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        nrem_d   = nrem_q;
        zero_d   = zero_q;
        raw_d    = raw_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(WIDTH);
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    nrem_d   = a_neg;
                    zero_d   = op[1] & (op2 == '0);
                    raw_d    = op1;
                    b_d      = b_mag;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    dbz_d    = 1'b0;
                end
            end
            S_RUN: begin
`ifdef MULDIV_FLUSH_EN
                if (flush) state_d = S_IDLE; else
`endif
                begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
`ifdef MULDIV_FLUSH_EN
                if (flush) state_d = S_IDLE; else
`endif
                begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    dbz_d   = zero_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            nrem_q   <= 1'b0;
            zero_q   <= 1'b0;
            raw_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            nrem_q   <= nrem_d;
            zero_q   <= zero_d;
            raw_q    <= raw_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
